// File: rtl/rbz_pkg.sv
// Shared types and constants for the raybox-zero debug probe, Caravel top and overlay logic.
package rbz_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_STRETCH = 2'd1,
    MODE_TOGGLE  = 2'd2,
    MODE_SAMPLE  = 2'd3
  } mode_e;

  typedef enum logic {
    GUARD_WAIT   = 1'b0,
    GUARD_LOCKED = 1'b1
  } guard_e;

  // o_overlay = {debug_overlay, map_overlay}
  localparam int OVL_MAP_BIT   = 0;
  localparam int OVL_DEBUG_BIT = 1;

  localparam int RBZ_NUM_CH   = 64;
  localparam int RBZ_RESERVED = 4;

endpackage

// File: rtl/rbz_sync.sv
// N-bit multi-flop synchroniser for quasi-static LA control inputs, with a synchronous clear.
module rbz_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the stage array is a flop chain rather than a RAM, so it is reset like any register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rbz_debug_probe.sv
// Debug-probe selector: synchronised, glitch-guarded select of one probe onto the debug pad,
// with direct/stretch/toggle/sample output modes and overlay-code decoding.
module rbz_debug_probe
  import rbz_pkg::*;
#(
  parameter int NUM_CH      = RBZ_NUM_CH,
  parameter int SEL_W       = 6,
  parameter int RESERVED    = RBZ_RESERVED,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD       = 3,
  parameter int STRETCH     = 15,
  parameter int DIV_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] i_probe,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [1:0]        i_mode,
  output logic              o_debug,
  output logic              o_sel_valid,
  output logic [1:0]        o_overlay,
  output logic [DIV_W-1:0]  o_div
);

  localparam int GCNT_W = $clog2(GUARD + 1);
  localparam int SCNT_W = $clog2(STRETCH + 1);
  localparam logic [SEL_W:0] RES_LO_C = (SEL_W+1)'(NUM_CH - RESERVED);
  localparam logic [SEL_W:0] NUM_CH_C = (SEL_W+1)'(NUM_CH);

  function automatic logic is_ovl(input logic [SEL_W-1:0] s);
    return ({1'b0, s} >= RES_LO_C) && ({1'b0, s} < NUM_CH_C);
  endfunction

  logic              clr_sync;
  logic [SEL_W-1:0]  sel_s, cand, active_sel;
  logic [1:0]        mode_raw_s;
  mode_e             mode_s, mode_q;
  guard_e            g_state, g_next;
  logic [GCNT_W-1:0] gcnt, gcnt_next;
  logic [SCNT_W-1:0] scnt, scnt_next;
  logic              sel_chg, adopt, mode_chg, clr_state;
  logic              is_probe, p, p_q, rise, tog, tog_next, pq_next, dbg_next;
  logic [1:0]        ovl_next;

  assign clr_sync = ~ena;

  rbz_sync #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sel_sync (
    .clk(clk), .reset_n(reset_n), .clr(clr_sync), .d(i_sel), .q(sel_s)
  );

  rbz_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_mode_sync (
    .clk(clk), .reset_n(reset_n), .clr(clr_sync), .d(i_mode), .q(mode_raw_s)
  );

  assign mode_s      = mode_e'(mode_raw_s);
  assign o_sel_valid = (g_state == GUARD_LOCKED);

  // Guard: a candidate must stay unchanged for GUARD compares before it becomes active.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    g_next    = g_state;
    gcnt_next = gcnt;
    adopt     = 1'b0;
    sel_chg   = (sel_s != cand);
    if (sel_chg) begin
      g_next    = GUARD_WAIT;
      gcnt_next = '0;
    end else if (g_state == GUARD_WAIT) begin
      if (gcnt == GCNT_W'(GUARD - 1)) begin
        adopt  = 1'b1;
        g_next = GUARD_LOCKED;
      end else begin
        gcnt_next = gcnt + 1'b1;
      end
    end
  end

  assign is_probe  = ({1'b0, active_sel} < RES_LO_C);
  assign p         = is_probe ? i_probe[active_sel] : 1'b0;
  assign rise      = p & ~p_q;
  assign mode_chg  = (mode_s != mode_q);
  assign clr_state = ~o_sel_valid | sel_chg | mode_chg;

  always_comb begin
    ovl_next = '0;
    if (is_ovl(cand)) begin
      ovl_next[OVL_DEBUG_BIT] = cand[1];
      ovl_next[OVL_MAP_BIT]   = cand[0];
    end
  end

  always_comb begin
    dbg_next  = o_debug;
    scnt_next = (scnt != '0) ? scnt - 1'b1 : scnt;
    tog_next  = tog ^ rise;
    pq_next   = p;
    if (rise) scnt_next = SCNT_W'(STRETCH);
    unique case (mode_s)
      MODE_DIRECT:  dbg_next = p;
      MODE_STRETCH: dbg_next = rise | (scnt != '0);
      MODE_TOGGLE:  dbg_next = tog ^ rise;
      MODE_SAMPLE:  if (o_div == '1) dbg_next = p;
    endcase
    if (!is_probe) dbg_next = 1'b0;
    if (clr_state) begin
      scnt_next = '0;
      tog_next  = 1'b0;
      pq_next   = 1'b0;
    end
    // A mode switch only resets history; the pad keeps its level for that one cycle.
    if (mode_chg) dbg_next = o_debug;
    if (!o_sel_valid || sel_chg) dbg_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_state    <= GUARD_WAIT;
      gcnt       <= '0;
      cand       <= '0;
      active_sel <= '0;
      o_overlay  <= '0;
      mode_q     <= MODE_DIRECT;
      scnt       <= '0;
      tog        <= 1'b0;
      p_q        <= 1'b0;
      o_debug    <= 1'b0;
      o_div      <= '0;
    end else if (!ena) begin
      g_state    <= GUARD_WAIT;
      gcnt       <= '0;
      cand       <= '0;
      active_sel <= '0;
      o_overlay  <= '0;
      mode_q     <= MODE_DIRECT;
      scnt       <= '0;
      tog        <= 1'b0;
      p_q        <= 1'b0;
      o_debug    <= 1'b0;
      o_div      <= '0;
    end else begin
      g_state <= g_next;
      gcnt    <= gcnt_next;
      cand    <= sel_s;
      if (adopt) begin
        active_sel <= cand;
        o_overlay  <= ovl_next;
      end
      mode_q  <= mode_s;
      scnt    <= scnt_next;
      tog     <= tog_next;
      p_q     <= pq_next;
      o_debug <= dbg_next;
      o_div   <= o_div + 1'b1;
    end
  end

endmodule

// File: tb/tb_rbz_debug_probe.sv
// Self-checking bench for rbz_debug_probe: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model built from sample histories.
module tb_rbz_debug_probe;

  localparam int NUM_CH = 64, SEL_W = 6, RESERVED = 4;
  localparam int SYNC_STAGES = 2, GUARD = 3, STRETCH = 15, DIV_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ena = 1'b0;
  logic [NUM_CH-1:0] i_probe = '0;
  logic [SEL_W-1:0]  i_sel = '0;
  logic [1:0]        i_mode = '0;
  logic              o_debug, o_sel_valid;
  logic [1:0]        o_overlay;
  logic [DIV_W-1:0]  o_div;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rbz_debug_probe #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .RESERVED(RESERVED), .SYNC_STAGES(SYNC_STAGES),
    .GUARD(GUARD), .STRETCH(STRETCH), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .i_probe(i_probe), .i_sel(i_sel),
    .i_mode(i_mode), .o_debug(o_debug), .o_sel_valid(o_sel_valid),
    .o_overlay(o_overlay), .o_div(o_div)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     sel_pipe [SYNC_STAGES];
  int     mode_pipe[SYNC_STAGES];
  int     hist[$];              // sel_s samples seen by the guard, oldest first
  bit     m_valid, m_dbg, p_prev, have_rise;
  int     m_active, m_overlay, m_mode_prev, m_div, n_rise;
  longint cyc, last_rise;
  bit     follow_div = 1'b0;
  int     follow_ch = 9;

  function automatic bit is_probe_code(int s);
    return s < NUM_CH - RESERVED;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sel_pipe[i]  = 0;
      mode_pipe[i] = 0;
    end
    hist = {0};
    m_valid = 0; m_dbg = 0; p_prev = 0; have_rise = 0;
    m_active = 0; m_overlay = 0; m_mode_prev = 0; m_div = 0; n_rise = 0;
    cyc = 0; last_rise = 0;
  endtask

  task automatic m_step();
    int sel_s, mode_s;
    bit sel_chg, new_valid, mode_chg, p, rise, dbg;
    sel_s   = sel_pipe[SYNC_STAGES-1];
    mode_s  = mode_pipe[SYNC_STAGES-1];
    sel_chg = (sel_s != hist[hist.size()-1]);
    hist.push_back(sel_s);
    if (hist.size() > GUARD + 1) void'(hist.pop_front());
    // Select is trusted once the last GUARD+1 guard samples all agree.
    new_valid = (hist.size() == GUARD + 1);
    foreach (hist[i]) if (hist[i] != sel_s) new_valid = 0;
    mode_chg = (mode_s != m_mode_prev);
    p    = is_probe_code(m_active) ? i_probe[m_active] : 1'b0;
    rise = p && !p_prev;
    if (rise) begin
      last_rise = cyc;
      have_rise = 1;
      n_rise++;
    end
    dbg = m_dbg;
    case (mode_s)
      0: dbg = p;
      1: dbg = have_rise && (cyc - last_rise <= STRETCH);
      2: dbg = n_rise[0];
      default: if (m_div == 2**DIV_W - 1) dbg = p;
    endcase
    if (!is_probe_code(m_active)) dbg = 0;
    if (mode_chg) dbg = m_dbg;
    if (!m_valid || sel_chg) dbg = 0;
    if (!m_valid || sel_chg || mode_chg) begin
      p_prev = 0; have_rise = 0; n_rise = 0;
    end else begin
      p_prev = p;
    end
    if (new_valid && !m_valid) begin
      m_active  = sel_s;
      m_overlay = (sel_s >= NUM_CH - RESERVED && sel_s < NUM_CH) ? sel_s % 4 : 0;
    end
    m_dbg       = dbg;
    m_valid     = new_valid;
    m_mode_prev = mode_s;
    m_div       = (m_div + 1) % (2**DIV_W);
    cyc++;
    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
      sel_pipe[i]  = sel_pipe[i-1];
      mode_pipe[i] = mode_pipe[i-1];
    end
    sel_pipe[0]  = int'(i_sel);
    mode_pipe[0] = int'(i_mode);
  endtask

  always @(posedge clk) begin
    if (!reset_n || !ena) m_clear();
    else m_step();
  end

  always @(negedge clk) begin
    check("o_debug", o_debug, m_dbg);
    check("o_sel_valid", o_sel_valid, m_valid);
    check("o_overlay", o_overlay, m_overlay);
    check("o_div", o_div, m_div);
  end

  always @(negedge clk) if (follow_div) i_probe[follow_ch] = m_div[0];

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hi, trans, bad, hold;
  bit prev, last9;
  logic [SEL_W-1:0] fav [4] = '{6'd5, 6'd9, 6'd61, 6'd62};

  initial begin
    m_clear();
    repeat (4) begin @(negedge clk); i_probe = ~i_probe; end
    #2 reset_n = 1'b1;
    repeat (10) begin @(negedge clk); i_probe = {$urandom, $urandom}; end
    check("ena_low_debug", o_debug, 0);
    check("ena_low_valid", o_sel_valid, 0);
    check("ena_low_overlay", o_overlay, 0);
    check("ena_low_div", o_div, 0);

    // select latency 0 -> 5
    i_probe = '0; i_sel = 0; i_mode = 0; ena = 1'b1;
    tick(12);
    check("sel0_valid", o_sel_valid, 1);
    i_probe[5] = 1'b1; i_sel = 5;
    tick(5);  check("lat_valid_c5", o_sel_valid, 0);
    tick(1);  check("lat_valid_c6", o_sel_valid, 1);
              check("lat_debug_c6", o_debug, 0);
    tick(1);  check("lat_debug_c7", o_debug, 1);

    // skew glitch 5 -> 13 (one cycle) -> 9
    i_probe[13] = 1'b1; i_probe[9] = 1'b1;
    i_sel = 13; tick(1); i_sel = 9;
    for (int e = 2; e <= 8; e++) begin
      tick(1);
      check("skew_overlay", o_overlay, 0);
      if (e >= 3 && e <= 7) check("skew_debug_low", o_debug, 0);
      if (e == 6) check("skew_valid_c6", o_sel_valid, 0);
      if (e == 7) check("skew_valid_c7", o_sel_valid, 1);
      if (e == 8) check("skew_debug_c8", o_debug, 1);
    end

    // STRETCH: single pulse, then retrigger
    i_probe = '0; i_mode = 1; tick(8);
    i_probe[9] = 1'b1; hi = 0;
    for (int k = 0; k < 30; k++) begin tick(1); i_probe[9] = 1'b0; hi += int'(o_debug); end
    check("stretch_single", hi, 16);
    i_probe[9] = 1'b1; hi = 0;
    for (int k = 0; k < 40; k++) begin tick(1); i_probe[9] = (k == 4); hi += int'(o_debug); end
    check("stretch_retrigger", hi, 21);

    // TOGGLE with probe = o_div[0]
    i_mode = 2; follow_ch = 9; follow_div = 1'b1; tick(8);
    prev = o_debug; trans = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (o_debug != prev) trans++;
      prev = o_debug;
    end
    check("toggle_transitions", trans, 8);

    // SAMPLE: pad changes only right after the all-ones divider count
    follow_div = 1'b0; i_mode = 3; tick(8);
    prev = o_debug; bad = 0; last9 = i_probe[9];
    for (int k = 0; k < 64; k++) begin
      tick(1);
      if (o_div == 0) check("sample_at_wrap", o_debug, last9);
      if (o_debug != prev && o_div != 0) bad++;
      prev = o_debug;
      i_probe[9] = $urandom_range(0, 1);
      last9 = i_probe[9];
    end
    check("sample_hold_off_wrap", bad, 0);

    // overlay codes
    i_probe = '1; i_mode = 0;
    i_sel = 62; tick(10);
    check("ovl62", o_overlay, 2'b10); check("ovl62_debug", o_debug, 0);
    i_sel = 63; tick(10); check("ovl63", o_overlay, 2'b11);
    i_sel = 61; tick(10); check("ovl61", o_overlay, 2'b01);
    i_sel = 20; tick(10);
    check("ovl_clear", o_overlay, 0); check("probe20_debug", o_debug, 1);

    // asynchronous reset mid-run
    #2 reset_n = 1'b0; m_clear();
    tick(1);
    check("reset_debug", o_debug, 0); check("reset_valid", o_sel_valid, 0);
    check("reset_overlay", o_overlay, 0); check("reset_div", o_div, 0);
    #2 reset_n = 1'b1;

    // ena low mid-stretch, then re-select
    tick(1); i_probe = '0; i_mode = 1; i_sel = 9; tick(12);
    i_probe[9] = 1'b1; tick(1); i_probe[9] = 1'b0; tick(3);
    check("stretch_pre_ena", o_debug, 1);
    ena = 1'b0; tick(1);
    check("ena_clr_debug", o_debug, 0); check("ena_clr_valid", o_sel_valid, 0);
    check("ena_clr_div", o_div, 0);
    ena = 1'b1;
    tick(5); check("reena_valid_c5", o_sel_valid, 0);
    tick(1); check("reena_valid_c6", o_sel_valid, 1);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      i_sel = ($urandom_range(0, 3) == 0) ? SEL_W'($urandom_range(0, 63)) : fav[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) i_mode = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 14);
      for (int k = 0; k < hold; k++) begin
        tick(1);
        i_probe = {$urandom, $urandom} & {$urandom, $urandom};
        ena = ($urandom_range(0, 199) != 0);
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
